// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_pkg
// Brief    : Note-code and octave constants shared by the key and LED paths.
// Revision : 1.0
// ============================================================================
package note_pkg;

    localparam logic [4:0] NOTE_REST        = 5'd0;
    localparam logic [4:0] NOTE_INVALID     = 5'd31;
    localparam int         NOTES_PER_OCTAVE = 7;

    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    // keys[6] is note 1 (do) ... keys[0] is note 7 (si)
    function automatic logic [4:0] encode_note(input logic [6:0] keys, input logic [1:0] oct);
        logic [2:0] cnt;
        logic [4:0] idx;
        cnt = 3'd0;
        idx = 5'd0;
        for (int b = 0; b < 7; b++) begin
            if (keys[b]) begin
                cnt = cnt + 3'd1;
                idx = 5'(7 - b);
            end
        end
        if (cnt == 3'd0)
            return NOTE_REST;
        else if (cnt != 3'd1)
            return NOTE_INVALID;
        else
            return 5'(oct) * 5'(NOTES_PER_OCTAVE) + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
// Module   : debounce
// Brief    : 2-flop synchronizer followed by a counter-based debouncer.
// Revision : 1.0
// ============================================================================
module debounce #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only survives while the synchronized input keeps disagreeing
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST)
                db_d = sync2_q;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = db_q;

endmodule
`default_nettype wire

// File: rtl/keys_to_note.sv
`default_nettype none
// ============================================================================
// Module   : keys_to_note
// Brief    : Debounced note keys and octave buttons to 5-bit note code.
//            Define KEYS_TO_NOTE_OCTAVE_WRAP_EN to wrap octave at the limits.
// Revision : 1.0
// ============================================================================
module keys_to_note #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] key,
    input  logic       oct_up,
    input  logic       oct_dn,
    output logic [4:0] note,
    output logic       note_valid,
    output logic [1:0] octave
);

    import note_pkg::*;

    logic [8:0] raw_w;
    logic [8:0] deb_w;
    logic [1:0] btn_prev_q;
    logic [1:0] octave_q;
    logic [1:0] octave_d;
    logic [4:0] note_q;
    logic [4:0] note_d;
    logic       note_valid_q;
    logic       up_rise_w;
    logic       dn_rise_w;

    assign raw_w = {oct_dn, oct_up, key};

    for (genvar g = 0; g < 9; g++) begin : g_deb
        debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .din_i  (raw_w[g]),
            .dout_o (deb_w[g])
        );
    end

    assign up_rise_w = deb_w[7] & ~btn_prev_q[0];
    assign dn_rise_w = deb_w[8] & ~btn_prev_q[1];

    always_comb begin
        octave_d = octave_q;
        if (up_rise_w && !dn_rise_w) begin
            if (octave_q == OCT_HIGH)
`ifdef KEYS_TO_NOTE_OCTAVE_WRAP_EN
                octave_d = OCT_LOW;
`else
                octave_d = OCT_HIGH;
`endif
            else
                octave_d = octave_q + 2'd1;
        end else if (dn_rise_w && !up_rise_w) begin
            if (octave_q == OCT_LOW)
`ifdef KEYS_TO_NOTE_OCTAVE_WRAP_EN
                octave_d = OCT_HIGH;
`else
                octave_d = OCT_LOW;
`endif
            else
                octave_d = octave_q - 2'd1;
        end
    end

    assign note_d = encode_note(deb_w[6:0], octave_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q   <= 2'b00;
            octave_q     <= OCT_MID;
            note_q       <= NOTE_REST;
            note_valid_q <= 1'b0;
        end else begin
            btn_prev_q   <= deb_w[8:7];
            octave_q     <= octave_d;
            note_q       <= note_d;
            note_valid_q <= (note_d != note_q);
        end
    end

    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign octave     = octave_q;

endmodule
`default_nettype wire
